uart_rx_frame_ctrl: RTL and testbench

Frame-level controller that sits above the `uart_rx` byte receiver. It programs the receiver's bit period and consumes its `done`/`data_bus` byte strobes. It parses framed packets (SYNC, LEN, payload, XOR checksum) into an internal buffer and releases only checksum-valid payloads on a valid/ready stream. On errors and stalls it resets the receiver, which recovers it from a stuck error state.

---
 rtl/uart_rx_frame_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller above a uart_rx byte receiver: parses SYNC/LEN/payload/XOR frames,
// streams checksum-valid payloads on valid/ready, and resets the receiver on errors.
module uart_rx_frame_ctrl #(
    parameter int         DIV0         = 5208,
    parameter int         DIV1         = 434,
    parameter int         DIV2         = 217,
    parameter int         DIV3         = 108,
    parameter logic [7:0] SYNC         = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  baud_sel,
    input  logic        cfg_load,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic [12:0] rx_clks_per_bit,
    output logic        rx_rst,
    output logic [7:0]  pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_last,
    output logic        pkt_err,
    output logic [1:0]  err_code
);

    localparam int         AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH   = 1 << AW;
    localparam logic [7:0] MAX_L   = 8'(MAX_LEN);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN, S_RECOVER
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  len, chk, idx, rd;
    logic [12:0] clk_cnt;
    logic [7:0]  bit_cnt;
    logic        rec_cnt;
    logic [7:0]  mem [0:DEPTH-1];
    logic        err_fire;
    logic [1:0]  err_sel;
    logic        timed, bit_end, timeout_hit, accept, enter_recover;

    function automatic logic [12:0] div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    div_of = 13'(DIV0);
            2'd1:    div_of = 13'(DIV1);
            2'd2:    div_of = 13'(DIV2);
            default: div_of = 13'(DIV3);
        endcase
    endfunction

    assign timed   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign bit_end = (clk_cnt == rx_clks_per_bit - 13'd1);
    // Fires on the edge that would make bit_cnt reach TIMEOUT_BITS; a byte on that edge wins.
    assign timeout_hit   = timed && !rx_done && bit_end && (bit_cnt == TO_LAST);
    assign accept        = pkt_valid && pkt_ready;
    assign enter_recover = (state_nxt == S_RECOVER) && (state != S_RECOVER);
    assign rx_rst        = rst && (state != S_RECOVER);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_fire  = 1'b0;
        err_sel   = 2'b00;
        case (state)
            S_IDLE: begin
                if (cfg_load)                         state_nxt = S_RECOVER;
                else if (rx_done && rx_data == SYNC)  state_nxt = S_LEN;
            end
            S_LEN: begin
                if (rx_done) begin
                    if (rx_data == 8'd0 || rx_data > MAX_L) begin
                        state_nxt = S_RECOVER;
                        err_fire  = 1'b1;
                        err_sel   = 2'b01;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_RECOVER;
                    err_fire  = 1'b1;
                    err_sel   = 2'b11;
                end
            end
            S_PAYLOAD: begin
                if (rx_done) begin
                    if (idx == len - 8'd1) state_nxt = S_CHK;
                end else if (timeout_hit) begin
                    state_nxt = S_RECOVER;
                    err_fire  = 1'b1;
                    err_sel   = 2'b11;
                end
            end
            S_CHK: begin
                if (rx_done) begin
                    if (rx_data == chk) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt = S_RECOVER;
                        err_fire  = 1'b1;
                        err_sel   = 2'b10;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_RECOVER;
                    err_fire  = 1'b1;
                    err_sel   = 2'b11;
                end
            end
            S_DRAIN: begin
                // A byte arriving while draining is lost; the drain itself carries on.
                if (rx_done) begin
                    err_fire = 1'b1;
                    err_sel  = 2'b00;
                end
                if (accept && pkt_last) state_nxt = S_IDLE;
            end
            S_RECOVER: begin
                if (rec_cnt) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_cnt         <= 13'd0;
            bit_cnt         <= 8'd0;
            rec_cnt         <= 1'b0;
            len             <= 8'd0;
            chk             <= 8'd0;
            idx             <= 8'd0;
            rd              <= 8'd0;
            rx_clks_per_bit <= 13'(DIV0);
            pkt_valid       <= 1'b0;
            pkt_data        <= 8'd0;
            pkt_last        <= 1'b0;
            pkt_err         <= 1'b0;
            err_code        <= 2'b00;
        end else begin
            pkt_err <= err_fire;
            if (err_fire) err_code <= err_sel;

            rec_cnt <= (state == S_RECOVER) && !rec_cnt;

            if (!timed || rx_done || state_nxt != state) begin
                clk_cnt <= 13'd0;
                bit_cnt <= 8'd0;
            end else if (bit_end) begin
                clk_cnt <= 13'd0;
                bit_cnt <= bit_cnt + 8'd1;
            end else begin
                clk_cnt <= clk_cnt + 13'd1;
            end

            if (enter_recover) begin
                rx_clks_per_bit <= div_of(baud_sel);
                idx             <= 8'd0;
                rd              <= 8'd0;
            end

            case (state)
                S_LEN: begin
                    if (rx_done) begin
                        len <= rx_data;
                        chk <= rx_data;
                        idx <= 8'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (rx_done) begin
                        chk <= chk ^ rx_data;
                        idx <= idx + 8'd1;
                    end
                end
                S_CHK: begin
                    if (rx_done) rd <= 8'd0;
                end
                default: ;
            endcase

            // Registered output slot: refills on the accepting edge for 1 byte/cycle.
            if (state == S_DRAIN) begin
                if ((!pkt_valid || pkt_ready) && rd < len) begin
                    pkt_valid <= 1'b1;
                    pkt_data  <= mem[rd[AW-1:0]];
                    pkt_last  <= (rd == len - 8'd1);
                    rd        <= rd + 8'd1;
                end else if (accept) begin
                    pkt_valid <= 1'b0;
                end
            end else begin
                pkt_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && rx_done) mem[idx[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level reference model feeding a scoreboard,
// with a monitor checking payload bytes, error pulses, handshake hold and receiver resets.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

    localparam int T_BITS = 20;
    localparam int MAXL   = 16;

    logic        clk = 1'b0;
    logic        rst, cfg_load, rx_done, pkt_ready;
    logic [1:0]  baud_sel;
    logic [7:0]  rx_data;
    logic [12:0] rx_clks_per_bit;
    logic        rx_rst, pkt_valid, pkt_last, pkt_err;
    logic [7:0]  pkt_data;
    logic [1:0]  err_code;

    uart_rx_frame_ctrl #(.MAX_LEN(MAXL), .TIMEOUT_BITS(T_BITS)) dut (
        .clk(clk), .rst(rst), .baud_sel(baud_sel), .cfg_load(cfg_load),
        .rx_done(rx_done), .rx_data(rx_data), .rx_clks_per_bit(rx_clks_per_bit),
        .rx_rst(rx_rst), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_last(pkt_last), .pkt_err(pkt_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_q[$];     // {last, data}
    logic [1:0] err_q[$];
    int         acc_cyc[$];
    int         last_done_cyc = 0;
    int         last_err_cyc = 0;
    logic [1:0] exp_code = 2'b00;

    bit   ready_rand = 1'b0;
    logic ready_force = 1'b1;
    always @(posedge clk) begin
        #1;
        pkt_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;
    int         low_run = 0;
    logic [8:0] mon_e;
    logic [1:0] mon_c;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            low_run    = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(pkt_valid), 32'd1);
                check("hold_data", 32'(pkt_data), 32'(prev_data));
                check("hold_last", 32'(pkt_last), 32'(prev_last));
            end
            if (pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", pkt_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pkt_byte", 32'({pkt_last, pkt_data}), 32'(mon_e));
                    acc_cyc.push_back(cyc);
                end
            end
            if (pkt_err) begin
                last_err_cyc = cyc;
                if (err_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: got code %0d expected no error", err_code);
                end else begin
                    mon_c = err_q.pop_front();
                    check("err_code", 32'(err_code), 32'(mon_c));
                end
            end
            if (!rx_rst) begin
                low_run++;
            end else if (low_run != 0) begin
                check("rx_rst_low_cycles", 32'(low_run), 32'd2);
                low_run = 0;
            end
            prev_stall = pkt_valid && !pkt_ready;
            prev_data  = pkt_data;
            prev_last  = pkt_last;
        end
    end

    // Reference model: whole-frame outcome from the framing rules.
    task automatic expect_frame(input logic [7:0] bs[$]);
        int n;
        logic [7:0] x;
        n = int'(bs[1]);
        if (n == 0 || n > MAXL) begin
            err_q.push_back(2'b01);
            exp_code = 2'b01;
            return;
        end
        x = bs[1];
        for (int i = 0; i < n; i++) x = x ^ bs[2+i];
        if (bs[2+n] != x) begin
            err_q.push_back(2'b10);
            exp_code = 2'b10;
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), bs[2+i]});
        end
    endtask

    task automatic make_frame(input int n, input bit bad_chk, output logic [7:0] bs[$]);
        logic [7:0] x;
        bs.delete();
        bs.push_back(8'hA5);
        bs.push_back(8'(n));
        x = 8'(n);
        for (int i = 0; i < n; i++) begin
            bs.push_back(8'($urandom_range(0, 255)));
            x = x ^ bs[2+i];
        end
        if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
        bs.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte is sampled on the next edge; gap idle cycles follow it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        last_done_cyc = cyc;
        rx_done = 1'b0;
        rx_data = 8'($urandom_range(0, 255));
        tick(gap);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$], input int gmin, input int gmax);
        foreach (bs[i]) send_byte(bs[i], int'($urandom_range(gmax, gmin)));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0 || pkt_valid) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_idle: timed out, %0d bytes and %0d errors outstanding",
                     exp_q.size(), err_q.size());
            exp_q.delete();
            err_q.delete();
        end
        tick(4);
        check("err_code_held", 32'(err_code), 32'(exp_code));
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!pkt_valid && n < budget) begin
            tick(1);
            n++;
        end
        check("valid_seen", 32'(pkt_valid), 32'd1);
    endtask

    task automatic do_cfg(input logic [1:0] sel, input int exp_div);
        baud_sel = sel;
        cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
        tick(4);
        check("clks_per_bit", 32'(rx_clks_per_bit), 32'(exp_div));
    endtask

    logic [7:0] bs[$];
    int d;

    initial begin
        rst = 1'b0; cfg_load = 1'b0; rx_done = 1'b0; rx_data = 8'd0; baud_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_rst", 32'(rx_rst), 32'd0);
        check("rst_clks", 32'(rx_clks_per_bit), 32'd5208);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_data", 32'(pkt_data), 32'd0);
        check("rst_last", 32'(pkt_last), 32'd0);
        check("rst_err", 32'(pkt_err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick(2);

        // Good frame, back-to-back delivery with fixed latency
        bs = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        acc_cyc.delete();
        expect_frame(bs);
        send_bytes(bs, 0, 0);
        d = last_done_cyc;
        wait_idle(100);
        check("accept_count", 32'(acc_cyc.size()), 32'd3);
        for (int i = 0; i < acc_cyc.size() && i < 3; i++)
            check("accept_cycle", 32'(acc_cyc[i] - d), 32'(i + 1));

        // Baud change, then a frame paced at 10 bit-times per byte
        do_cfg(2'd2, 217);
        make_frame(3, 1'b0, bs);
        expect_frame(bs);
        send_bytes(bs, 10 * 217 - 1, 10 * 217 - 1);
        wait_idle(100);

        // Bad checksum, bad lengths, then recovery with a good frame
        bs = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        expect_frame(bs); send_bytes(bs, 0, 0); wait_idle(100);
        bs = '{8'hA5, 8'h00};
        expect_frame(bs); send_bytes(bs, 0, 0); wait_idle(100);
        bs = '{8'hA5, 8'h11};
        expect_frame(bs); send_bytes(bs, 0, 0); wait_idle(100);
        make_frame(5, 1'b0, bs);
        expect_frame(bs); send_bytes(bs, 0, 1); wait_idle(100);

        // Inter-byte timeout
        err_q.push_back(2'b11);
        exp_code = 2'b11;
        bs = '{8'hA5, 8'h02, 8'h11};
        send_bytes(bs, 0, 0);
        d = last_done_cyc;
        wait_idle(6000);
        check("timeout_cycles", 32'(last_err_cyc - d), 32'(T_BITS * 217));

        // Backpressure: first byte held while stalled
        ready_force = 1'b0;
        tick(2);
        bs = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        expect_frame(bs);
        send_bytes(bs, 0, 0);
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check("stall_data", 32'(pkt_data), 32'h11);
            tick(1);
        end
        ready_force = 1'b1;
        wait_idle(100);

        // Overrun during drain; payload still delivered
        ready_force = 1'b0;
        tick(2);
        bs = '{8'hA5, 8'h02, 8'h44, 8'h55, 8'h13};
        expect_frame(bs);
        send_bytes(bs, 0, 0);
        wait_valid(10);
        err_q.push_back(2'b00);
        exp_code = 2'b00;
        send_byte(8'h77, 2);
        ready_force = 1'b1;
        wait_idle(100);

        // Reset during drain aborts silently and restores defaults
        ready_force = 1'b0;
        tick(2);
        make_frame(4, 1'b0, bs);
        send_bytes(bs, 0, 0);
        wait_valid(10);
        rst = 1'b0;
        exp_code = 2'b00;
        tick(2);
        check("mid_rst_rx_rst", 32'(rx_rst), 32'd0);
        check("mid_rst_valid", 32'(pkt_valid), 32'd0);
        check("mid_rst_clks", 32'(rx_clks_per_bit), 32'd5208);
        rst = 1'b1;
        ready_force = 1'b1;
        tick(2);
        make_frame(4, 1'b0, bs);
        expect_frame(bs); send_bytes(bs, 0, 0); wait_idle(100);

        // Byte landing on the exact timeout edge is accepted
        do_cfg(2'd3, 108);
        bs = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        expect_frame(bs);
        send_bytes(bs, T_BITS * 108 - 1, T_BITS * 108 - 1);
        wait_idle(100);

        // cfg_load beats a simultaneous SYNC; trailing bytes land in IDLE
        cfg_load = 1'b1;
        send_byte(8'hA5, 4);
        cfg_load = 1'b0;
        bs = '{8'h01, 8'h5A, 8'h5B};
        send_bytes(bs, 0, 0);
        wait_idle(100);
        check("cfg_sync_clks", 32'(rx_clks_per_bit), 32'd108);

        // Randomized frames with random backpressure and leading noise
        ready_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            logic [7:0] g;
            kind = int'($urandom_range(0, 9));
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, int'($urandom_range(0, 2)));
            end
            if (kind < 6) begin
                make_frame(int'($urandom_range(1, MAXL)), 1'b0, bs);
            end else if (kind < 8) begin
                make_frame(int'($urandom_range(1, MAXL)), 1'b1, bs);
            end else begin
                bs = '{8'hA5, 8'h00};
                if ($urandom_range(0, 1) == 1) bs[1] = 8'($urandom_range(MAXL + 1, 255));
            end
            expect_frame(bs);
            send_bytes(bs, 0, 3);
            wait_idle(2000);
        end
        ready_rand = 1'b0;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
